// File: rtl/cc_dispatch_pkg.sv
// Shared encodings for the two-way stream dispatcher.
package cc_dispatch_pkg;

  typedef enum logic {
    CC_DISPATCH_MODE_SELECT = 1'b0,
    CC_DISPATCH_MODE_RR     = 1'b1
  } mode_e;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } ch_e;

endpackage

// File: rtl/cc_dispatch_slot.sv
// One-entry output buffer: data register, valid flag and wrapping accept counter.
module cc_dispatch_slot #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          ready_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);

  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] count_q, count_d;

  // A load in the same cycle as a drain wins, keeping the slot full.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
      count_d = count_q + CW'(1);
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/cc_dispatch_c.sv
// Two-way stream dispatcher: steers each input word to one of two one-entry
// channels, by select bit or round-robin, with per-channel word counts.
module cc_dispatch_c
  import cc_dispatch_pkg::*;
#(
  parameter int unsigned NUMBER_DATAWIDTH  = 8,
  parameter int unsigned NUMBER_COUNTWIDTH = 8
) (
  input  logic                         CC_DISPATCH_C_CLOCK_50,
  input  logic                         CC_DISPATCH_C_RESET_InHigh,
  input  logic [NUMBER_DATAWIDTH-1:0]  CC_DISPATCH_C_data_In,
  input  logic                         CC_DISPATCH_C_valid_In,
  input  logic                         CC_DISPATCH_C_select_In,
  input  logic                         CC_DISPATCH_C_mode_In,
  output logic                         CC_DISPATCH_C_ready_Out,
  output logic [NUMBER_DATAWIDTH-1:0]  CC_DISPATCH_C_data0_Out,
  output logic [NUMBER_DATAWIDTH-1:0]  CC_DISPATCH_C_data1_Out,
  output logic                         CC_DISPATCH_C_valid0_Out,
  output logic                         CC_DISPATCH_C_valid1_Out,
  input  logic                         CC_DISPATCH_C_ready0_In,
  input  logic                         CC_DISPATCH_C_ready1_In,
  output logic [NUMBER_COUNTWIDTH-1:0] CC_DISPATCH_C_count0_Out,
  output logic [NUMBER_COUNTWIDTH-1:0] CC_DISPATCH_C_count1_Out
);

  ch_e  pointer_q, pointer_d;
  ch_e  target;
  logic rr_mode;
  logic accept;
  logic load0, load1;

  // ready_Out is a function of slot state only, never of valid_In.
  always_comb begin
    rr_mode = (mode_e'(CC_DISPATCH_C_mode_In) == CC_DISPATCH_MODE_RR);
    target  = rr_mode ? pointer_q : ch_e'(CC_DISPATCH_C_select_In);
    if (target == CH0)
      CC_DISPATCH_C_ready_Out = !CC_DISPATCH_C_valid0_Out || CC_DISPATCH_C_ready0_In;
    else
      CC_DISPATCH_C_ready_Out = !CC_DISPATCH_C_valid1_Out || CC_DISPATCH_C_ready1_In;
    accept    = CC_DISPATCH_C_valid_In && CC_DISPATCH_C_ready_Out;
    load0     = accept && (target == CH0);
    load1     = accept && (target == CH1);
    pointer_d = pointer_q;
    if (accept && rr_mode)
      pointer_d = (pointer_q == CH0) ? CH1 : CH0;
  end

  always_ff @(posedge CC_DISPATCH_C_CLOCK_50) begin
    if (CC_DISPATCH_C_RESET_InHigh)
      pointer_q <= CH0;
    else
      pointer_q <= pointer_d;
  end

  cc_dispatch_slot #(
    .DW(NUMBER_DATAWIDTH),
    .CW(NUMBER_COUNTWIDTH)
  ) u_slot0 (
    .clk     (CC_DISPATCH_C_CLOCK_50),
    .rst     (CC_DISPATCH_C_RESET_InHigh),
    .load_i  (load0),
    .data_i  (CC_DISPATCH_C_data_In),
    .ready_i (CC_DISPATCH_C_ready0_In),
    .data_o  (CC_DISPATCH_C_data0_Out),
    .valid_o (CC_DISPATCH_C_valid0_Out),
    .count_o (CC_DISPATCH_C_count0_Out)
  );

  cc_dispatch_slot #(
    .DW(NUMBER_DATAWIDTH),
    .CW(NUMBER_COUNTWIDTH)
  ) u_slot1 (
    .clk     (CC_DISPATCH_C_CLOCK_50),
    .rst     (CC_DISPATCH_C_RESET_InHigh),
    .load_i  (load1),
    .data_i  (CC_DISPATCH_C_data_In),
    .ready_i (CC_DISPATCH_C_ready1_In),
    .data_o  (CC_DISPATCH_C_data1_Out),
    .valid_o (CC_DISPATCH_C_valid1_Out),
    .count_o (CC_DISPATCH_C_count1_Out)
  );

endmodule

// File: tb/tb_cc_dispatch_c.sv
// Directed bench for cc_dispatch_c with hand-computed expectations.
module tb_cc_dispatch_c;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       valid_in, select_in, mode_in;
  logic       ready_out;
  logic [7:0] data0, data1;
  logic       valid0, valid1;
  logic       ready0, ready1;
  logic [7:0] count0, count1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  cc_dispatch_c #(
    .NUMBER_DATAWIDTH (8),
    .NUMBER_COUNTWIDTH(8)
  ) dut (
    .CC_DISPATCH_C_CLOCK_50     (clk),
    .CC_DISPATCH_C_RESET_InHigh (rst),
    .CC_DISPATCH_C_data_In      (data_in),
    .CC_DISPATCH_C_valid_In     (valid_in),
    .CC_DISPATCH_C_select_In    (select_in),
    .CC_DISPATCH_C_mode_In      (mode_in),
    .CC_DISPATCH_C_ready_Out    (ready_out),
    .CC_DISPATCH_C_data0_Out    (data0),
    .CC_DISPATCH_C_data1_Out    (data1),
    .CC_DISPATCH_C_valid0_Out   (valid0),
    .CC_DISPATCH_C_valid1_Out   (valid1),
    .CC_DISPATCH_C_ready0_In    (ready0),
    .CC_DISPATCH_C_ready1_In    (ready1),
    .CC_DISPATCH_C_count0_Out   (count0),
    .CC_DISPATCH_C_count1_Out   (count1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_in = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; data_in = 8'hFF; valid_in = 1'b1; select_in = 1'b0;
    mode_in = 1'b1; ready0 = 1'b1; ready1 = 1'b1;

    // Reset held two cycles with a valid word on the input.
    tick(); tick();
    chk("rst_valid0", valid0, 1'b0);
    chk("rst_valid1", valid1, 1'b0);
    chk("rst_data0", data0, 8'h00);
    chk("rst_data1", data1, 8'h00);
    chk("rst_count0", count0, 8'h00);
    chk("rst_count1", count1, 8'h00);
    rst = 1'b0; data_in = 8'h77;
    tick();
    chk("rr_first_valid0", valid0, 1'b1);
    chk("rr_first_data0", data0, 8'h77);
    chk("rr_first_valid1", valid1, 1'b0);
    chk("rr_first_count0", count0, 8'h01);

    // Select mode.
    do_reset();
    mode_in = 1'b0; valid_in = 1'b1; data_in = 8'hA5; select_in = 1'b1;
    tick();
    chk("sel_data1", data1, 8'hA5);
    chk("sel_valid1", valid1, 1'b1);
    data_in = 8'h3C; select_in = 1'b0;
    tick();
    chk("sel_data0", data0, 8'h3C);
    chk("sel_valid0", valid0, 1'b1);
    chk("sel_valid1_drained", valid1, 1'b0);
    chk("sel_count0", count0, 8'h01);
    chk("sel_count1", count1, 8'h01);

    // Back-pressure on ch0.
    do_reset();
    mode_in = 1'b0; select_in = 1'b0; ready0 = 1'b0; valid_in = 1'b1; data_in = 8'h11;
    settle();
    chk("bp_ready_empty", ready_out, 1'b1);
    tick();
    chk("bp_data0_first", data0, 8'h11);
    data_in = 8'h22;
    settle();
    chk("bp_ready_stall", ready_out, 1'b0);
    tick();
    chk("bp_data0_hold", data0, 8'h11);
    chk("bp_count0_hold", count0, 8'h01);
    ready0 = 1'b1;
    settle();
    chk("bp_ready_release", ready_out, 1'b1);
    tick();
    chk("bp_data0_second", data0, 8'h22);
    chk("bp_count0_second", count0, 8'h02);
    valid_in = 1'b0;
    tick();
    chk("bp_drain_valid0", valid0, 1'b0);

    // Round-robin back-to-back with both consumers ready.
    do_reset();
    mode_in = 1'b1; ready0 = 1'b1; ready1 = 1'b1; valid_in = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      data_in = 8'(i);
      settle();
      chk("rr_ready", ready_out, 1'b1);
      tick();
      if (i % 2 == 1) begin
        chk("rr_data0", data0, 32'(i));
        chk("rr_valid0", valid0, 1'b1);
      end else begin
        chk("rr_data1", data1, 32'(i));
        chk("rr_valid1", valid1, 1'b1);
      end
    end
    chk("rr_count0", count0, 8'h03);
    chk("rr_count1", count1, 8'h03);

    // Round-robin pointer holds across stalled valid cycles.
    do_reset();
    mode_in = 1'b1; ready0 = 1'b0; ready1 = 1'b1; valid_in = 1'b1;
    data_in = 8'hC0; tick();
    data_in = 8'hC1; tick();
    data_in = 8'hC2;
    settle();
    chk("rrh_stall_ready", ready_out, 1'b0);
    tick(); tick();
    chk("rrh_data0_hold", data0, 8'hC0);
    ready0 = 1'b1;
    tick();
    chk("rrh_data0_next", data0, 8'hC2);
    chk("rrh_count0", count0, 8'h02);
    chk("rrh_count1", count1, 8'h01);

    // Counter wrap on ch1.
    do_reset();
    mode_in = 1'b0; select_in = 1'b1; ready1 = 1'b1; valid_in = 1'b1;
    for (int i = 0; i < 255; i++) begin
      data_in = 8'(i);
      tick();
    end
    chk("wrap_count1_ff", count1, 8'hFF);
    data_in = 8'hEE;
    tick();
    chk("wrap_count1_zero", count1, 8'h00);
    chk("wrap_count0", count0, 8'h00);
    chk("wrap_data1", data1, 8'hEE);

    // Reset while ch0 is full and stalled.
    do_reset();
    mode_in = 1'b0; select_in = 1'b0; ready0 = 1'b0; valid_in = 1'b1; data_in = 8'h5A;
    tick();
    data_in = 8'h6B;
    settle();
    chk("mid_stall_ready", ready_out, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0; valid_in = 1'b0;
    chk("mid_valid0", valid0, 1'b0);
    chk("mid_count0", count0, 8'h00);
    settle();
    chk("mid_ready", ready_out, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cc_dispatch_c.md
# cc_dispatch_c

Two-way stream dispatcher: the fan-out counterpart of the datapath's bitwise merge stages. It accepts one NUMBER_DATAWIDTH-bit word stream with a valid/ready handshake and steers each word to one of two buffered output channels, either by an explicit select bit or by alternating round-robin. It sits between a single producer (register file or ALU result bus) and two independent consumers, and keeps per-channel word counts for debug.

## Interface

- NUMBER_DATAWIDTH, 8, width of data words
- NUMBER_COUNTWIDTH, 8, width of each per-channel word counter

- CC_DISPATCH_C_CLOCK_50  in  1  system clock; all logic on rising edge
- CC_DISPATCH_C_RESET_InHigh  in  1  synchronous reset, active-high
- CC_DISPATCH_C_data_In  in  NUMBER_DATAWIDTH  input word
- CC_DISPATCH_C_valid_In  in  1  input word present
- CC_DISPATCH_C_select_In  in  1  target channel when mode = 0 (0 → ch0, 1 → ch1)
- CC_DISPATCH_C_mode_In  in  1  0 = steer by select, 1 = round-robin
- CC_DISPATCH_C_ready_Out  out  1  input word accepted this cycle if valid_In also high
- CC_DISPATCH_C_data0_Out / CC_DISPATCH_C_data1_Out  out  NUMBER_DATAWIDTH  channel words
- CC_DISPATCH_C_valid0_Out / CC_DISPATCH_C_valid1_Out  out  1  channel word present
- CC_DISPATCH_C_ready0_In / CC_DISPATCH_C_ready1_In  in  1  consumer takes channel word
- CC_DISPATCH_C_count0_Out / CC_DISPATCH_C_count1_Out  out  NUMBER_COUNTWIDTH  words accepted into each channel

## Operation

- Reset is synchronous and active-high: while the reset is high at a rising edge, all channel valids → 0, channel data → 0, counters → 0, round-robin pointer → 0. Reset mid-operation discards buffered words without handshake.
- Target channel t = select_In when mode_In = 0; t = pointer when mode_In = 1.
- Each channel holds one entry (data register + valid flag).
- ready_Out = (valid_t = 0) OR (ready_t_In = 1). Combinational from slot state, mode, select, pointer and consumer ready; never depends on valid_In.
- Accept = valid_In AND ready_Out. On accept: slot t loads data_In, valid_t → 1, count_t increments (wraps 2^NUMBER_COUNTWIDTH−1 → 0).
- Channel drain: valid_k AND ready_k_In at an edge with no accept into k → valid_k → 0. Drain and accept on the same channel in the same cycle → slot reloads, valid stays 1 (full throughput).
- The non-target channel drains independently in the same cycle.
- Pointer toggles only on an accept while mode_In = 1; holds otherwise (including non-accepted valid cycles and mode = 0).
- Mode changes take effect the same cycle; already-buffered words are unaffected.
- Channel data is held stable while valid_k = 1 and ready_k_In = 0.

## Timing

- Latency: word accepted at edge k is visible on data_t/valid_t after edge k (one register stage).
- Sustained rate: one word per cycle when the target consumer holds ready high; round-robin with both consumers ready gives one word per cycle alternating ch0, ch1.
- Stall: target slot full and consumer ready low → ready_Out low, input held by producer; other channel may still drain.
- Counters update on the same edge as the accept.
- No combinational path from valid_In to any output.

## Structure

- Package cc_dispatch_pkg: mode constants (CC_DISPATCH_MODE_SELECT = 1'b0, CC_DISPATCH_MODE_RR = 1'b1), channel index constants (CH0 = 1'b0, CH1 = 1'b1).
- One sub-module, cc_dispatch_slot: one-entry buffer with load/drain, valid flag and wrapping counter; instantiated twice. Top level holds pointer, target selection and ready logic.

## Test plan

- Reset: drive data_In = 8'hFF, valid_In = 1, reset high 2 cycles → both valids 0, data 8'h00, counts 0, pointer 0; first post-reset round-robin word goes to ch0.
- Select mode: mode 0, send 8'hA5 sel 1, 8'h3C sel 0, both consumers ready → data1 = 8'hA5 one cycle after accept, data0 = 8'h3C next cycle; count0 = count1 = 1.
- Back-pressure: mode 0, sel 0, ready0_In low, send 8'h11 then 8'h22 → ready_Out low after first accept, data0 holds 8'h11; raise ready0_In → 8'h22 accepted that cycle, appears next cycle.
- Round-robin throughput: mode 1, both ready, send 8'h01..8'h06 back-to-back → ch0 gets 01,03,05, ch1 gets 02,04,06, ready_Out never low, counts 3/3.
- Counter wrap: 256 words into ch1 → count1 returns to 8'h00, count0 unchanged.
- Reset mid-stream: ch0 full and stalled, reset one cycle → valid0 0, count0 0, ready_Out 1 next cycle.
